// File: rtl/cmp_sort4_ctrl.sv
// cmp_sort4_ctrl: bubble-sorts four 3-bit values using one shared comparator, one compare per clock
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   i_in_valid/o_in_ready/i_in_data    - load handshake (ready while loading)
//   o_out_valid/i_out_ready/o_out_data - sorted stream, smallest first
//   o_busy            - high while sorting
//   o_swap_count      - swaps performed by the last or current sort
module comparatoeB (
  input  logic [2:0] A,
  input  logic [2:0] B,
  output logic       A_greater_B,
  output logic       A_equal_B
);
  assign A_greater_B = A > B;
  assign A_equal_B   = A == B;
endmodule

module cmp_sort4_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  input  logic [2:0] i_in_data,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic [2:0] o_out_data,
  output logic       o_busy,
  output logic [2:0] o_swap_count
);
  localparam int W = 3;
  localparam int N = 4;
  typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;
  state_t         r_state;
  logic [W-1:0]   r_data [N];
  logic [1:0]     r_ld, r_rd, r_i, r_pass;
  logic           r_flag;
  logic [2:0]     r_swaps;
  logic [W-1:0]   w_a, w_b;
  logic           w_gt, w_eq, w_last;
  assign w_a    = r_data[r_i];
  assign w_b    = r_data[r_i + 2'd1];
  // each pass bubbles the largest remaining value to the end, so the pass shortens by one
  assign w_last = r_i == 2'd2 - r_pass;
  comparatoeB u_cmp (.A(w_a), .B(w_b), .A_greater_B(w_gt), .A_equal_B(w_eq));
  assign o_in_ready   = r_state == LOAD;
  assign o_busy       = r_state == SORT;
  assign o_out_valid  = r_state == OUT;
  assign o_out_data   = r_data[r_rd];
  assign o_swap_count = r_swaps;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOAD;
      r_ld    <= '0;
      r_rd    <= '0;
      r_i     <= '0;
      r_pass  <= '0;
      r_flag  <= 1'b0;
      r_swaps <= '0;
      for (int k = 0; k < N; k++) r_data[k] <= '0;
    end else begin
      case (r_state)
        LOAD: if (i_in_valid) begin
          r_data[r_ld] <= i_in_data;
          r_ld         <= r_ld + 2'd1;
          if (r_ld == 2'd0) r_swaps <= '0;
          if (r_ld == 2'd3) begin
            r_state <= SORT;
            r_i     <= '0;
            r_pass  <= '0;
            r_flag  <= 1'b0;
          end
        end
        SORT: begin
          // equal elements never swap (w_eq unused beyond the compare), keeping the sort stable
          if (w_gt && !w_eq) begin
            r_data[r_i]        <= w_b;
            r_data[r_i + 2'd1] <= w_a;
            r_swaps            <= r_swaps + 3'd1;
          end
          if (w_last) begin
            if (!(r_flag || w_gt) || r_pass == 2'd2) r_state <= OUT;
            else begin
              r_pass <= r_pass + 2'd1;
              r_i    <= '0;
              r_flag <= 1'b0;
            end
          end else begin
            r_i    <= r_i + 2'd1;
            r_flag <= r_flag | w_gt;
          end
        end
        OUT: if (i_out_ready) begin
          r_rd <= r_rd + 2'd1;
          if (r_rd == 2'd3) begin
            r_state <= LOAD;
            r_ld    <= '0;
            r_rd    <= '0;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_cmp_sort4_ctrl.sv
// tb_cmp_sort4_ctrl: directed vector bench for cmp_sort4_ctrl
module tb_cmp_sort4_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       i_in_valid, i_out_ready;
  logic [2:0] i_in_data;
  logic       o_in_ready, o_out_valid, o_busy;
  logic [2:0] o_out_data, o_swap_count;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0][2:0] d;
    logic [3:0][2:0] e;
    logic [3:0]      c;
    logic [2:0]      s;
    logic            stall;
    logic            poke;
  } vec_t;

  cmp_sort4_ctrl dut (
    .clk(clk), .rst(rst),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
    .o_busy(o_busy), .o_swap_count(o_swap_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int a, b, c, d, ea, eb, ec, ed, cyc, sw, st, pk);
    vec_t v;
    v.d = {3'(d), 3'(c), 3'(b), 3'(a)};
    v.e = {3'(ed), 3'(ec), 3'(eb), 3'(ea)};
    v.c = 4'(cyc);
    v.s = 3'(sw);
    v.stall = st[0];
    v.poke = pk[0];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0][2:0] d);
    for (int k = 0; k < 4; k++) begin
      i_in_valid = 1'b1;
      i_in_data  = d[k];
      tick();
    end
    i_in_valid = 1'b0;
    i_in_data  = 3'd0;
  endtask

  task automatic run(input vec_t v);
    int n;
    load(v.d);
    n = 0;
    while (o_busy && n < 20) begin
      if (v.poke) begin
        i_in_valid = (n == 1);
        i_in_data  = 3'd7;
      end
      n++;
      tick();
    end
    i_in_valid = 1'b0;
    check("busy_cycles", n, int'(v.c));
    check("out_valid_after_sort", int'(o_out_valid), 1);
    check("swap_count", int'(o_swap_count), int'(v.s));
    if (v.stall) begin
      i_out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
        check("stall_valid", int'(o_out_valid), 1);
        check("stall_data", int'(o_out_data), int'(v.e[0]));
        tick();
      end
    end
    i_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("out_valid", int'(o_out_valid), 1);
      check("out_data", int'(o_out_data), int'(v.e[k]));
      tick();
    end
    i_out_ready = 1'b0;
    check("in_ready_after_out", int'(o_in_ready), 1);
    check("out_valid_after_out", int'(o_out_valid), 0);
    check("swap_count_held", int'(o_swap_count), int'(v.s));
  endtask

  vec_t tbl [4];

  initial begin
    tbl[0] = mk(5, 2, 7, 0, 0, 2, 5, 7, 6, 4, 0, 1);
    tbl[1] = mk(1, 3, 4, 6, 1, 3, 4, 6, 3, 0, 1, 0);
    tbl[2] = mk(7, 6, 5, 4, 4, 5, 6, 7, 6, 6, 0, 0);
    tbl[3] = mk(3, 3, 3, 3, 3, 3, 3, 3, 3, 0, 0, 0);
    rst = 1'b1;
    i_in_valid = 1'b0;
    i_in_data = 3'd0;
    i_out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", int'(o_in_ready), 1);
    check("rst_out_valid", int'(o_out_valid), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_out_data", int'(o_out_data), 0);
    check("rst_swap_count", int'(o_swap_count), 0);
    for (int t = 0; t < 4; t++) run(tbl[t]);
    load({3'd0, 3'd7, 3'd2, 3'd5});
    tick();
    tick();
    check("mid_sort_busy", int'(o_busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", int'(o_in_ready), 1);
    check("midrst_busy", int'(o_busy), 0);
    check("midrst_out_valid", int'(o_out_valid), 0);
    check("midrst_swap_count", int'(o_swap_count), 0);
    run(mk(2, 1, 0, 3, 0, 1, 2, 3, 6, 3, 0, 0));
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cmp_sort4_ctrl.md
# cmp_sort4_ctrl

Sequencing controller that shares one 3-bit magnitude comparator (`comparatoeB`: ports A, B, A_greater_B, A_equal_B) to sort four 3-bit values ascending. It uses bubble sort with early exit and issues one comparison per clock. It accepts four values through a valid/ready load port, sorts them in place, then streams them out through a valid/ready output port. It reports the number of swaps performed and is the first sequential user of the comparator datapath.

## Interface
- `W`, 3, element width; fixed to comparator width, not overridable.
- `N`, 4, number of elements; fixed.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  load data valid.
- `in_ready`  out  1  high while in LOAD.
- `in_data`  in  3  value to load.
- `out_valid`  out  1  high while in OUT.
- `out_ready`  in  1  consumer accepts `out_data`.
- `out_data`  out  3  current sorted element, smallest first.
- `busy`  out  1  high while in SORT.
- `swap_count`  out  3  swaps performed in the last or current sort (0..6).

## Operation
- Storage: `r[0..3]`, each 3 bits. One internal `comparatoeB` instance, with A = `r[i]` and B = `r[i+1]`.
- States: LOAD, SORT, OUT. Reset enters LOAD.
- LOAD
  - `in_ready`=1.
  - On `in_valid & in_ready`, write `in_data` to `r[ld_cnt]` and increment `ld_cnt`.
  - The first accept of a batch clears `swap_count`.
  - The 4th accept moves to SORT with pass=0, i=0, and the pass-swap flag clear.
- SORT
  - Each cycle compares pair (i, i+1). If A_greater_B, swap `r[i]` and `r[i+1]`, increment `swap_count`, and set the pass-swap flag.
  - Equal values are never swapped (A_equal_B means no swap), so the sort is stable.
  - The last index of a pass is 2-pass.
  - At the last index of a pass:
    - If no swap happened in the pass (including this cycle's result), go to OUT.
    - If pass=2, go to OUT.
    - Otherwise increment pass, set i=0, and clear the flag.
- OUT
  - `out_valid`=1 and `out_data`=`r[rd_cnt]`.
  - On `out_valid & out_ready`, increment `rd_cnt`.
  - The 4th transfer returns to LOAD with `ld_cnt`=`rd_cnt`=0.
- `in_valid` is ignored outside LOAD. `out_ready` is ignored outside OUT.
- `swap_count` holds its value through OUT and the following LOAD, until the next batch's first accept.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=0, `swap_count`=0.
  - `r[*]`=0, all counters 0.
- `rst` overrides all activity in any state, including mid-SORT and mid-OUT: the next cycle is LOAD with a clean batch, and partial loads are discarded.
- `in_ready`, `out_valid` and `busy` decode directly from registered state, with no combinational path from `in_valid` or `out_ready`.
- SORT latency:
  - `busy` rises the cycle after the 4th load accept.
  - SORT lasts C cycles, one per compare. C=3 for already-sorted input, C=6 at most.
  - `out_valid` rises the cycle after the last compare edge.
- Output throughput is one element per cycle with `out_ready` held high: 4 cycles in OUT, then `in_ready` is 1 the following cycle.
- `out_data` holds stable while `out_valid & ~out_ready`.
- Width rule: `swap_count` cannot exceed 6, so it does not wrap.

## Test plan
- Load 5,2,7,0 -> `busy` for exactly 6 cycles; output 0,2,5,7; `swap_count`=4.
- Load 1,3,4,6 (already sorted) -> `busy` for exactly 3 cycles (early exit); output 1,3,4,6; `swap_count`=0.
- Load 7,6,5,4 -> `busy` for 6 cycles; output 4,5,6,7; `swap_count`=6.
- Load 3,3,3,3 -> 3 SORT cycles; output 3,3,3,3; `swap_count`=0.
- Backpressure and ignored inputs:
  - Hold `out_ready`=0 for 5 cycles in OUT -> `out_data` stays at the smallest value and `out_valid` stays 1.
  - Pulse `in_valid` with `in_data`=7 during SORT -> the value is not stored and results are unchanged.
- Reset mid-operation:
  - Assert `rst` one cycle during SORT (batch 5,2,7,0) -> next cycle `in_ready`=1, `busy`=0, `out_valid`=0, `swap_count`=0.
  - A fresh load of 2,1,0,3 then outputs 0,1,2,3 with `swap_count`=3.
